dlx_fetch_unit: RTL

//  Instruction-fetch stage of the 5-stage DLX pipeline, and the producer end of the IF/ID interface that the ID control decoder consumes.
//  - Owns the PC and runs a req/ack handshake with instruction memory.
//  - Loads the IF/ID register with instr, pc_plus_four, valid and kill.
//  - Honours stall, branch-redirect and kill-next commands returned by ID.

---
 rtl/dlx_fetch_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dlx_fetch_unit.sv
// DLX instruction-fetch stage: owns the PC, talks req/ack to instruction memory
// and loads the IF/ID register consumed by the ID control decoder.
// Optional build macro IF_PERF_COUNTERS_EN adds perf_fetched/perf_squashed counters.
module dlx_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0015
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [0:31] imem_rdata,
    input  logic        id_stall,
    input  logic        id_branch,
    input  logic [31:0] id_new_pc,
    input  logic        id_kill_next,
    output logic [0:31] if_instr,
    output logic [31:0] if_pc_plus_four,
    output logic        if_valid,
    output logic        if_kill
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);

    typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic [0:31] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;
    logic        req_q;
    logic [0:31] instr_d;
    logic [31:0] pc4_d;
    logic        valid_d, kill_d;
    logic        ack_ok;
    logic [31:0] pc_plus_four;
    logic [31:0] new_pc_aligned;

    assign imem_req       = !reset && (state_q != StHold);
    assign imem_addr      = pc_q;
    // An ack in the very first cycle of a request is stale (memory needs >= 1 cycle).
    assign ack_ok         = imem_ack && imem_req && req_q;
    assign pc_plus_four   = pc_q + 32'd4;
    assign new_pc_aligned = id_new_pc & ~32'h0000_0003;

    // Next-state for FSM, PC, hold buffer and IF/ID; priority branch > kill > stall.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        instr_d      = if_instr;
        pc4_d        = if_pc_plus_four;
        valid_d      = if_valid;
        kill_d       = if_kill;

        if (id_branch) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            kill_d  = 1'b0;
            // Still waiting on an ack: let it land on the old address before redirecting.
            if (state_q != StHold && !ack_ok) begin
                state_d  = StDrain;
                target_d = new_pc_aligned;
            end else begin
                state_d = StFetch;
                pc_d    = new_pc_aligned;
            end
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (id_kill_next) begin
                        if (ack_ok) begin
                            instr_d = imem_rdata;
                            pc4_d   = pc_plus_four;
                            valid_d = 1'b1;
                            kill_d  = 1'b1;
                        end else begin
                            instr_d = NOP_INSTR;
                            valid_d = 1'b0;
                            kill_d  = 1'b0;
                        end
                    end else if (id_stall) begin
                        if (ack_ok) begin
                            hold_instr_d = imem_rdata;
                            hold_pc4_d   = pc_plus_four;
                            state_d      = StHold;
                        end
                    end else if (ack_ok) begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_plus_four;
                        valid_d = 1'b1;
                        kill_d  = 1'b0;
                        pc_d    = pc_plus_four;
                    end else begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                        kill_d  = 1'b0;
                    end
                end
                StHold: begin
                    if (id_kill_next) begin
                        instr_d = hold_instr_q;
                        pc4_d   = hold_pc4_q;
                        valid_d = 1'b1;
                        kill_d  = 1'b1;
                    end else if (!id_stall) begin
                        instr_d = hold_instr_q;
                        pc4_d   = hold_pc4_q;
                        valid_d = 1'b1;
                        kill_d  = 1'b0;
                        pc_d    = hold_pc4_q;
                        state_d = StFetch;
                    end
                end
                StDrain: begin
                    if (ack_ok) begin
                        pc_d    = target_q;
                        state_d = StFetch;
                    end
                    if (id_kill_next || !id_stall) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                        kill_d  = 1'b0;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    // State and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StFetch;
            pc_q            <= RESET_PC;
            target_q        <= RESET_PC;
            hold_instr_q    <= NOP_INSTR;
            hold_pc4_q      <= 32'd0;
            req_q           <= 1'b0;
            if_instr        <= NOP_INSTR;
            if_pc_plus_four <= 32'd0;
            if_valid        <= 1'b0;
            if_kill         <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            target_q        <= target_d;
            hold_instr_q    <= hold_instr_d;
            hold_pc4_q      <= hold_pc4_d;
            req_q           <= imem_req;
            if_instr        <= instr_d;
            if_pc_plus_four <= pc4_d;
            if_valid        <= valid_d;
            if_kill         <= kill_d;
        end
    end

`ifdef IF_PERF_COUNTERS_EN
    logic fetch_inc, squash_inc;

    // Classify this edge's IF/ID load for the counters.
    always_comb begin
        fetch_inc  = !reset && !id_branch && !id_kill_next && !id_stall &&
                     ((state_q == StFetch && ack_ok) || state_q == StHold);
        squash_inc = !reset &&
                     ((id_kill_next && !id_branch &&
                       (state_q == StHold || (state_q == StFetch && ack_ok))) ||
                      (state_q == StDrain && ack_ok) ||
                      (id_branch && state_q == StHold));
    end

    // Free-running wrapping event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched  <= 32'd0;
            perf_squashed <= 32'd0;
        end else begin
            perf_fetched  <= perf_fetched + {31'd0, fetch_inc};
            perf_squashed <= perf_squashed + {31'd0, squash_inc};
        end
    end
`endif

endmodule
